prbs13_checker: RTL and testbench

//  Receive-side PRBS-13 checker for the BERT datapath; sits downstream of the PRBS-13 generator, after the channel/loopback.

---
 rtl/prbs_pkg.sv | 25 ++
 rtl/prbs_sat_counter.sv | 40 ++++
 rtl/prbs13_checker.sv | 168 ++++++++++++++++
 tb/tb_prbs13_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared PRBS-13 constants, checker state encoding and LFSR feedback.
// Revision : 1.0
// ============================================================================
`default_nettype none

package prbs_pkg;

  localparam int          PRBS13_LEN  = 13;
  localparam logic [12:0] PRBS13_TAPS = 13'h100D;  // taps r[12], r[3], r[2], r[0]

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  function automatic logic prbs13_fb(input logic [12:0] r);
    return ^(r & PRBS13_TAPS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs_sat_counter.sv
// ============================================================================
// Module   : prbs_sat_counter
// Purpose  : Event counter with synchronous clear; saturates when
//            PRBS_CHK_SAT_EN is defined, otherwise wraps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prbs_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
`ifdef PRBS_CHK_SAT_EN
    end else if (i_inc && !(&r_count)) begin
`else
    end else if (i_inc) begin
`endif
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/prbs13_checker.sv
// ============================================================================
// Module   : prbs13_checker
// Purpose  : Self-synchronising PRBS-13 receive checker with lock/sync-loss
//            detection and bit/error counters.
// Config   : define PRBS_CHK_SAT_EN for saturating counters (default wraps).
// Revision : 1.0
// ============================================================================
`default_nettype none

module prbs13_checker
  import prbs_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int LOCK_CNT   = 32,
  parameter int ERR_WIN    = 64,
  parameter int ERR_THRESH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_rx_bit,
  input  logic             i_rx_valid,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic             o_sync_loss_pulse,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(ERR_WIN + 1);
  localparam int WERR_W  = $clog2(ERR_THRESH + 1);

  prbs_state_e        r_state;
  prbs_state_e        w_state_nxt;
  logic [12:0]        r_lfsr;
  logic [3:0]         r_seed_cnt;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [WERR_W-1:0]  r_win_err;
  logic               r_locked;
  logic               r_err_pulse;
  logic               r_sync_loss;

  logic               w_fb;
  logic               w_mismatch;
  logic [12:0]        w_shift_rx;
  logic               w_seed_done;
  logic               w_lock_hit;
  logic               w_win_end;
  logic [WERR_W-1:0]  w_win_err_inc;
  logic               w_thresh_hit;
  logic               w_locked_bit;
  logic               w_err_pulse_nxt;
  logic               w_sync_loss_nxt;

  assign w_fb          = prbs13_fb(r_lfsr);
  assign w_mismatch    = i_rx_bit ^ w_fb;
  assign w_shift_rx    = {r_lfsr[11:0], i_rx_bit};
  assign w_seed_done   = (r_seed_cnt == 4'(PRBS13_LEN - 1));
  assign w_lock_hit    = (r_match_cnt == MATCH_W'(LOCK_CNT - 1));
  assign w_win_end     = (r_win_cnt == WIN_W'(ERR_WIN - 1));
  assign w_win_err_inc = r_win_err + WERR_W'(w_mismatch);
  assign w_thresh_hit  = (w_win_err_inc >= WERR_W'(ERR_THRESH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_SEED;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_rx_valid) begin
      case (r_state)
        ST_SEED:   if (w_seed_done && (w_shift_rx != 13'd0)) w_state_nxt = ST_VERIFY;
        ST_VERIFY: begin
          if (w_mismatch)      w_state_nxt = ST_SEED;
          else if (w_lock_hit) w_state_nxt = ST_LOCKED;
        end
        ST_LOCKED: if (w_thresh_hit) w_state_nxt = ST_SEED;
        default:   w_state_nxt = ST_SEED;
      endcase
    end
  end

  always_comb begin
    w_locked_bit    = i_rx_valid && (r_state == ST_LOCKED);
    w_err_pulse_nxt = w_locked_bit && w_mismatch;
    w_sync_loss_nxt = w_locked_bit && w_thresh_hit;
  end

  // In LOCKED the LFSR free-runs on its own prediction so a line error cannot corrupt it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr      <= '0;
      r_seed_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_sync_loss <= 1'b0;
    end else begin
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err_pulse <= w_err_pulse_nxt;
      r_sync_loss <= w_sync_loss_nxt;
      if (i_rx_valid) begin
        case (r_state)
          ST_SEED: begin
            r_lfsr      <= w_shift_rx;
            r_seed_cnt  <= w_seed_done ? 4'd0 : r_seed_cnt + 4'd1;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
          end
          ST_VERIFY: begin
            r_lfsr      <= w_shift_rx;
            r_seed_cnt  <= '0;
            r_match_cnt <= (w_mismatch || w_lock_hit) ? '0 : r_match_cnt + MATCH_W'(1);
            r_win_cnt   <= '0;
            r_win_err   <= '0;
          end
          ST_LOCKED: begin
            r_lfsr      <= {r_lfsr[11:0], w_fb};
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            if (w_win_end || w_thresh_hit) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
              r_win_err <= w_win_err_inc;
            end
          end
          default: begin
            r_lfsr     <= w_shift_rx;
            r_seed_cnt <= '0;
          end
        endcase
      end
    end
  end

  prbs_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_locked_bit),
    .i_clear (i_clear),
    .o_count (o_bit_count)
  );

  prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_err_pulse_nxt),
    .i_clear (i_clear),
    .o_count (o_err_count)
  );

  assign o_state           = r_state;
  assign o_locked          = r_locked;
  assign o_err_pulse       = r_err_pulse;
  assign o_sync_loss_pulse = r_sync_loss;

endmodule

`default_nettype wire

// File: tb/tb_prbs13_checker.sv
// Directed bench for prbs13_checker: lock, single error, sync loss, zero stream,
// clear, gapped valid with async reset, and narrow-counter wrap/saturate.
`default_nettype none

module tb_prbs13_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_rx_bit;
  logic        i_rx_valid;
  logic        i_clear;
  logic        o_locked, o_err_pulse, o_sync_loss_pulse;
  logic [1:0]  o_state;
  logic [31:0] o_bit_count, o_err_count;
  logic        n_locked, n_err_pulse, n_sync_loss_pulse;
  logic [1:0]  n_state;
  logic [3:0]  n_bit_count, n_err_count;

  int          vec  = 0;
  int          errs = 0;
  logic [12:0] g;

  always #5 clock = ~clock;

  prbs13_checker dut (
    .clock(clock), .reset(reset), .i_rx_bit(i_rx_bit), .i_rx_valid(i_rx_valid),
    .i_clear(i_clear), .o_locked(o_locked), .o_err_pulse(o_err_pulse),
    .o_sync_loss_pulse(o_sync_loss_pulse), .o_state(o_state),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count)
  );

  prbs13_checker #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .i_rx_bit(i_rx_bit), .i_rx_valid(i_rx_valid),
    .i_clear(i_clear), .o_locked(n_locked), .o_err_pulse(n_err_pulse),
    .o_sync_loss_pulse(n_sync_loss_pulse), .o_state(n_state),
    .o_bit_count(n_bit_count), .o_err_count(n_err_count)
  );

  task automatic gen(output logic b);
    b = g[12] ^ g[3] ^ g[2] ^ g[0];
    g = {g[11:0], b};
  endtask

  task automatic step(input logic b, input logic v);
    i_rx_bit   = b;
    i_rx_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen(b);
      step(b, 1'b1);
    end
  endtask

  task automatic do_reset;
    i_rx_valid = 1'b0;
    i_rx_bit   = 1'b0;
    i_clear    = 1'b0;
    reset      = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    vec++; if (o_state !== 2'd0) begin errs++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    vec++; if (o_locked !== 1'b0) begin errs++; $display("FAIL reset_locked: got %b expected 0", o_locked); end
    vec++; if ({o_err_pulse, o_sync_loss_pulse} !== 2'b00) begin errs++; $display("FAIL reset_pulses: got %b expected 00", {o_err_pulse, o_sync_loss_pulse}); end
    vec++; if ({o_bit_count, o_err_count} !== 64'd0) begin errs++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", o_bit_count, o_err_count); end
  endtask

  task automatic test_lock;
    logic b;
    int   lock_at = 0;
    int   pulses  = 0;
    do_reset();
    g = 13'h000F;
    for (int k = 1; k <= 1000; k++) begin
      gen(b);
      step(b, 1'b1);
      if (o_locked === 1'b1 && lock_at == 0) lock_at = k;
      if (o_err_pulse !== 1'b0) pulses++;
    end
    vec++; if (lock_at != 45) begin errs++; $display("FAIL lock_bit: got %0d expected 45", lock_at); end
    vec++; if (o_bit_count !== 32'd955) begin errs++; $display("FAIL lock_bit_count: got %0d expected 955", o_bit_count); end
    vec++; if (o_err_count !== 32'd0) begin errs++; $display("FAIL lock_err_count: got %0d expected 0", o_err_count); end
    vec++; if (pulses != 0) begin errs++; $display("FAIL lock_err_pulses: got %0d expected 0", pulses); end
    vec++; if (o_state !== 2'd2) begin errs++; $display("FAIL lock_state: got %0d expected 2", o_state); end
  endtask

  task automatic test_single_error;
    logic b;
    int   pulses = 0;
    clean(5);
    gen(b);
    step(~b, 1'b1);
    vec++; if (o_err_pulse !== 1'b1) begin errs++; $display("FAIL single_err_pulse: got %b expected 1", o_err_pulse); end
    vec++; if (o_err_count !== 32'd1) begin errs++; $display("FAIL single_err_count: got %0d expected 1", o_err_count); end
    vec++; if (o_locked !== 1'b1 || o_sync_loss_pulse !== 1'b0) begin errs++; $display("FAIL single_err_lock: got locked=%b loss=%b expected 1/0", o_locked, o_sync_loss_pulse); end
    for (int i = 0; i < 20; i++) begin
      clean(1);
      if (o_err_pulse !== 1'b0) pulses++;
    end
    vec++; if (pulses != 0) begin errs++; $display("FAIL single_err_followup_pulses: got %0d expected 0", pulses); end
    vec++; if (o_err_count !== 32'd1) begin errs++; $display("FAIL single_err_held: got %0d expected 1", o_err_count); end
    vec++; if (o_bit_count !== 32'd981) begin errs++; $display("FAIL single_err_bit_count: got %0d expected 981", o_bit_count); end
  endtask

  task automatic test_sync_loss;
    logic b;
    int   early = 0;
    do_reset();
    g = 13'h0ABC;
    clean(45);
    vec++; if (o_locked !== 1'b1) begin errs++; $display("FAIL loss_prelock: got %b expected 1", o_locked); end
    for (int i = 0; i < 8; i++) begin
      gen(b);
      step(~b, 1'b1);
      if (i < 7 && (o_locked !== 1'b1 || o_sync_loss_pulse !== 1'b0)) early++;
    end
    vec++; if (early != 0) begin errs++; $display("FAIL loss_early: got %0d early drops expected 0", early); end
    vec++; if (o_sync_loss_pulse !== 1'b1) begin errs++; $display("FAIL loss_pulse: got %b expected 1", o_sync_loss_pulse); end
    vec++; if (o_state !== 2'd0 || o_locked !== 1'b0) begin errs++; $display("FAIL loss_state: got state=%0d locked=%b expected 0/0", o_state, o_locked); end
    vec++; if (o_err_count !== 32'd8) begin errs++; $display("FAIL loss_err_count: got %0d expected 8", o_err_count); end
    clean(1);
    vec++; if (o_sync_loss_pulse !== 1'b0) begin errs++; $display("FAIL loss_pulse_width: got %b expected 0", o_sync_loss_pulse); end
    clean(43);
    vec++; if (o_locked !== 1'b0) begin errs++; $display("FAIL relock_early: got %b expected 0", o_locked); end
    clean(1);
    vec++; if (o_locked !== 1'b1) begin errs++; $display("FAIL relock: got %b expected 1", o_locked); end
    vec++; if (o_err_count !== 32'd8 || o_bit_count !== 32'd8) begin errs++; $display("FAIL relock_counts: got %0d/%0d expected 8/8", o_bit_count, o_err_count); end
  endtask

  task automatic test_zero_stream;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1);
      if (o_state !== 2'd0 || o_locked !== 1'b0) bad++;
    end
    vec++; if (bad != 0) begin errs++; $display("FAIL zero_stays_seed: got %0d bad cycles expected 0", bad); end
    vec++; if ({o_bit_count, o_err_count} !== 64'd0) begin errs++; $display("FAIL zero_counts: got %0d/%0d expected 0/0", o_bit_count, o_err_count); end
  endtask

  task automatic test_clear;
    logic b;
    do_reset();
    g = 13'h1234;
    clean(50);
    gen(b);
    step(~b, 1'b1);
    clean(4);
    vec++; if (o_bit_count !== 32'd10 || o_err_count !== 32'd1) begin errs++; $display("FAIL clear_pre: got %0d/%0d expected 10/1", o_bit_count, o_err_count); end
    i_clear = 1'b1;
    gen(b);
    step(b, 1'b1);
    i_clear = 1'b0;
    vec++; if (o_bit_count !== 32'd0 || o_err_count !== 32'd0) begin errs++; $display("FAIL clear_wins: got %0d/%0d expected 0/0", o_bit_count, o_err_count); end
    vec++; if (o_locked !== 1'b1) begin errs++; $display("FAIL clear_keeps_lock: got %b expected 1", o_locked); end
    clean(1);
    vec++; if (o_bit_count !== 32'd1 || o_err_count !== 32'd0) begin errs++; $display("FAIL clear_post: got %0d/%0d expected 1/0", o_bit_count, o_err_count); end
  endtask

  task automatic test_valid_gaps;
    logic b;
    logic j;
    int   lock_at = 0;
    do_reset();
    g = 13'h0F0F;
    for (int k = 1; k <= 60; k++) begin
      gen(b);
      step(b, 1'b1);
      if (o_locked === 1'b1 && lock_at == 0) lock_at = k;
      j = 1'($urandom_range(0, 1));
      step(j, 1'b0);
    end
    vec++; if (lock_at != 45) begin errs++; $display("FAIL gap_lock_bit: got %0d expected 45", lock_at); end
    vec++; if (o_bit_count !== 32'd15) begin errs++; $display("FAIL gap_bit_count: got %0d expected 15", o_bit_count); end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vec++; if (o_state !== 2'd0 || o_locked !== 1'b0) begin errs++; $display("FAIL async_reset_state: got state=%0d locked=%b expected 0/0", o_state, o_locked); end
    vec++; if ({o_bit_count, o_err_count} !== 64'd0 || {o_err_pulse, o_sync_loss_pulse} !== 2'b00) begin errs++; $display("FAIL async_reset_outputs: got %0d/%0d pulses=%b expected 0/0/00", o_bit_count, o_err_count, {o_err_pulse, o_sync_loss_pulse}); end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_narrow_counter;
    logic [3:0] exp4;
`ifdef PRBS_CHK_SAT_EN
    exp4 = 4'd15;
`else
    exp4 = 4'd4;
`endif
    do_reset();
    g = 13'h0555;
    clean(45);
    vec++; if (n_locked !== 1'b1) begin errs++; $display("FAIL narrow_lock: got %b expected 1", n_locked); end
    clean(20);
    vec++; if (n_bit_count !== exp4) begin errs++; $display("FAIL narrow_bit_count: got %0d expected %0d", n_bit_count, exp4); end
    vec++; if (o_bit_count !== 32'd20) begin errs++; $display("FAIL wide_bit_count: got %0d expected 20", o_bit_count); end
  endtask

  initial begin
    reset      = 1'b1;
    i_rx_bit   = 1'b0;
    i_rx_valid = 1'b0;
    i_clear    = 1'b0;
    test_reset();
    test_lock();
    test_single_error();
    test_sync_loss();
    test_zero_stream();
    test_clear();
    test_valid_gaps();
    test_narrow_counter();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
